// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : Sequences CPU load/store requests onto a synchronous single-port
//            RAM (one-cycle read latency). Loads return registered data with
//            an rvalid pulse per word; every access ends with a done pulse.
//            Optional feature macro: MEMCTRL_BURST_EN enables multi-word
//            loads of burst_len+1 words with address wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
  parameter int A = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         req,
  input  logic         we,
  input  logic [A-1:0] cpu_addr,
  input  logic [W-1:0] cpu_wdata,
  input  logic [3:0]   burst_len,
  output logic         busy,
  output logic         done,
  output logic         rvalid,
  output logic [W-1:0] rdata,
  output logic [A-1:0] mem_addr,
  output logic [W-1:0] mem_datain,
  output logic         mem_enable,
  output logic         mem_read_en,
  output logic         mem_write_en,
  input  logic [W-1:0] mem_dataout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2,
    S_WR   = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [A-1:0] r_addr;
  logic [W-1:0] r_wdata;
  logic [3:0]   r_cnt;
  logic         r_rd_pend;
  logic [3:0]   w_len;

`ifdef MEMCTRL_BURST_EN
  assign w_len = burst_len;
`else
  // Single-word loads only; the length input is deliberately not consumed.
  logic w_unused_burst_len;
  assign w_unused_burst_len = ^burst_len;
  assign w_len              = 4'd0;
`endif

  // State register; the async reset aborts any access in flight.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; any unexpected encoding falls back to IDLE.
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_nxt = req ? (we ? S_WR : S_RD) : S_IDLE;
      S_RD:    w_state_nxt = (r_cnt == 4'd0) ? S_CAP : S_RD;
      S_CAP:   w_state_nxt = S_IDLE;
      S_WR:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // RAM strobes decode straight from state so reset clears them at once.
  assign busy         = (r_state != S_IDLE);
  assign mem_enable   = (r_state == S_RD) || (r_state == S_CAP) || (r_state == S_WR);
  assign mem_read_en  = (r_state == S_RD);
  assign mem_write_en = (r_state == S_WR);
  assign mem_addr     = r_addr;
  assign mem_datain   = r_wdata;

  // Request latch plus burst address/count stepping while reading.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= 4'd0;
    end else if (r_state == S_IDLE && req) begin
      r_addr  <= cpu_addr;
      r_wdata <= cpu_wdata;
      r_cnt   <= we ? 4'd0 : w_len;
    end else if (r_state == S_RD && r_cnt != 4'd0) begin
      r_addr  <= r_addr + 1'b1;
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  // Completion and read-return pipeline: a read strobed at one edge has its
  // RAM data available for capture at the following edge.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      done      <= 1'b0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      done      <= (r_state == S_WR) || (r_state == S_CAP);
      r_rd_pend <= (r_state == S_RD);
      rvalid    <= r_rd_pend;
      if (r_rd_pend) rdata <= mem_dataout;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module   : tb_mem_access_ctrl
// Brief    : Directed self-checking bench for mem_access_ctrl with a
//            behavioural synchronous RAM (one-cycle read latency).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [7:0] cpu_addr = 8'h00;
  logic [7:0] cpu_wdata = 8'h00;
  logic [3:0] burst_len = 4'd0;
  logic       busy, done, rvalid;
  logic [7:0] rdata, mem_addr, mem_datain, mem_dataout;
  logic       mem_enable, mem_read_en, mem_write_en;

  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = 8'h00;
  logic [7:0] pre_data = 8'h00;
  logic [7:0] ram [256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.A(8), .W(8)) dut (
    .clk          (clk),
    .clear        (clear),
    .req          (req),
    .we           (we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .burst_len    (burst_len),
    .busy         (busy),
    .done         (done),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .mem_addr     (mem_addr),
    .mem_datain   (mem_datain),
    .mem_enable   (mem_enable),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_dataout  (mem_dataout)
  );

  // Synchronous RAM with a bench-side preload port.
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_enable && mem_write_en) ram[mem_addr] <= mem_datain;
    if (mem_enable && mem_read_en) mem_dataout <= ram[mem_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  // ctl = {busy, done, rvalid, mem_enable, mem_read_en, mem_write_en}
  task automatic test_reset;
    logic [5:0] ctl;
    clear = 1'b0;
    tick(); tick();
    ctl = {busy, done, rvalid, mem_enable, mem_read_en, mem_write_en};
    total++;
    if (ctl !== 6'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 6'b0); end
    total++;
    if ({rdata, mem_addr, mem_datain} !== 24'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=%h", {rdata, mem_addr, mem_datain}, 24'h0);
    end
    clear = 1'b1;
    tick();
  endtask

  task automatic test_store;
    logic [5:0] ctl;
    req = 1'b1; we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
    tick();
    req = 1'b0;
    ctl = {busy, done, rvalid, mem_enable, mem_read_en, mem_write_en};
    total++;
    if (ctl !== 6'b100101) begin bad++; $display("FAIL store_wr_ctl got=%b exp=%b", ctl, 6'b100101); end
    total++;
    if ({mem_addr, mem_datain} !== 16'h10A5) begin
      bad++; $display("FAIL store_wr_bus got=%h exp=%h", {mem_addr, mem_datain}, 16'h10A5);
    end
    tick();
    ctl = {busy, done, rvalid, mem_enable, mem_read_en, mem_write_en};
    total++;
    if (ctl !== 6'b010000) begin bad++; $display("FAIL store_done_ctl got=%b exp=%b", ctl, 6'b010000); end
    total++;
    if (ram[8'h10] !== 8'hA5) begin bad++; $display("FAIL store_ram got=%h exp=%h", ram[8'h10], 8'hA5); end
    tick();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL store_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_load;
    logic [5:0] ctl;
    preload(8'd23, 8'h1E);
    req = 1'b1; we = 1'b0; cpu_addr = 8'd23;
    tick();
    req = 1'b0;
    ctl = {busy, done, rvalid, mem_enable, mem_read_en, mem_write_en};
    total++;
    if (ctl !== 6'b100110 || mem_addr !== 8'd23) begin
      bad++; $display("FAIL load_rd got=%b/%h exp=%b/%h", ctl, mem_addr, 6'b100110, 8'd23);
    end
    tick();
    ctl = {busy, done, rvalid, mem_enable, mem_read_en, mem_write_en};
    total++;
    if (ctl !== 6'b100100) begin bad++; $display("FAIL load_cap got=%b exp=%b", ctl, 6'b100100); end
    tick();
    ctl = {busy, done, rvalid, mem_enable, mem_read_en, mem_write_en};
    total++;
    if (ctl !== 6'b011000 || rdata !== 8'h1E) begin
      bad++; $display("FAIL load_done got=%b/%h exp=%b/%h", ctl, rdata, 6'b011000, 8'h1E);
    end
    tick();
    total++;
    if ({done, rvalid} !== 2'b00 || rdata !== 8'h1E) begin
      bad++; $display("FAIL load_hold got=%b/%h exp=%b/%h", {done, rvalid}, rdata, 2'b00, 8'h1E);
    end
  endtask

  task automatic test_burst;
    logic [7:0] exp_addr [4];
    logic [7:0] exp_data [4];
    exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;
    exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33; exp_data[3] = 8'h44;
    for (int i = 0; i < 4; i++) preload(exp_addr[i], exp_data[i]);
    req = 1'b1; we = 1'b0; cpu_addr = 8'hFE; burst_len = 4'd3;
    tick();
    req = 1'b0;
`ifdef MEMCTRL_BURST_EN
    // Cycle c (1-based after acceptance): reads in cycles 1..4, words in 3..6.
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4) begin
        total++;
        if (mem_read_en !== 1'b1 || mem_addr !== exp_addr[c-1]) begin
          bad++; $display("FAIL burst_addr%0d got=%b/%h exp=1/%h", c, mem_read_en, mem_addr, exp_addr[c-1]);
        end
      end
      if (c >= 3) begin
        total++;
        if (rvalid !== 1'b1 || rdata !== exp_data[c-3] || done !== (c == 6)) begin
          bad++; $display("FAIL burst_word%0d got=%b/%h/%b exp=1/%h/%b", c, rvalid, rdata, done, exp_data[c-3], (c == 6));
        end
      end else begin
        total++;
        if ({rvalid, done} !== 2'b00) begin bad++; $display("FAIL burst_early%0d got=%b exp=00", c, {rvalid, done}); end
      end
      tick();
    end
    total++;
    if ({busy, done, rvalid} !== 3'b000) begin bad++; $display("FAIL burst_end got=%b exp=000", {busy, done, rvalid}); end
`else
    total++;
    if (mem_read_en !== 1'b1 || mem_addr !== 8'hFE) begin
      bad++; $display("FAIL single_rd got=%b/%h exp=1/fe", mem_read_en, mem_addr);
    end
    tick();
    total++;
    if (mem_read_en !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL single_cap got=%b/%b exp=0/1", mem_read_en, busy);
    end
    tick();
    total++;
    if ({done, rvalid} !== 2'b11 || rdata !== 8'h11) begin
      bad++; $display("FAIL single_done got=%b/%h exp=11/11", {done, rvalid}, rdata);
    end
    tick();
    total++;
    if ({busy, done, rvalid} !== 3'b000) begin bad++; $display("FAIL single_end got=%b exp=000", {busy, done, rvalid}); end
`endif
    burst_len = 4'd0;
  endtask

  task automatic test_clear_mid_write;
    logic [5:0] ctl;
    preload(8'h30, 8'h77);
    req = 1'b1; we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'h99;
    tick();
    req = 1'b0;
    total++;
    if (mem_write_en !== 1'b1) begin bad++; $display("FAIL abort_pre got=%b exp=1", mem_write_en); end
    #2 clear = 1'b0;
    #1;
    ctl = {busy, done, rvalid, mem_enable, mem_read_en, mem_write_en};
    total++;
    if (ctl !== 6'b0 || {rdata, mem_addr, mem_datain} !== 24'h0) begin
      bad++; $display("FAIL abort_now got=%b/%h exp=0/0", ctl, {rdata, mem_addr, mem_datain});
    end
    tick();
    total++;
    if (ram[8'h30] !== 8'h77 || done !== 1'b0) begin
      bad++; $display("FAIL abort_ram got=%h/%b exp=77/0", ram[8'h30], done);
    end
    clear = 1'b1;
    tick();
    total++;
    if ({busy, done, mem_enable} !== 3'b000) begin bad++; $display("FAIL abort_after got=%b exp=000", {busy, done, mem_enable}); end
  endtask

  task automatic test_back_to_back;
    logic [5:0] ctl;
    req = 1'b1; we = 1'b0; cpu_addr = 8'd23;
    tick();
    // Held request with new operands must not disturb the running load.
    we = 1'b1; cpu_addr = 8'h50; cpu_wdata = 8'h3C;
    tick();
    ctl = {busy, done, rvalid, mem_enable, mem_read_en, mem_write_en};
    total++;
    if (ctl !== 6'b100100 || mem_addr !== 8'd23) begin
      bad++; $display("FAIL b2b_ignored got=%b/%h exp=%b/%h", ctl, mem_addr, 6'b100100, 8'd23);
    end
    tick();
    ctl = {busy, done, rvalid, mem_enable, mem_read_en, mem_write_en};
    total++;
    if (ctl !== 6'b011000 || rdata !== 8'h1E) begin
      bad++; $display("FAIL b2b_done got=%b/%h exp=%b/1e", ctl, rdata, 6'b011000);
    end
    tick();
    req = 1'b0;
    ctl = {busy, done, rvalid, mem_enable, mem_read_en, mem_write_en};
    total++;
    if (ctl !== 6'b100101 || {mem_addr, mem_datain} !== 16'h503C) begin
      bad++; $display("FAIL b2b_new got=%b/%h exp=%b/503c", ctl, {mem_addr, mem_datain}, 6'b100101);
    end
    tick();
    total++;
    if ({busy, done} !== 2'b01 || ram[8'h50] !== 8'h3C) begin
      bad++; $display("FAIL b2b_wr_done got=%b/%h exp=01/3c", {busy, done}, ram[8'h50]);
    end
    tick();
    total++;
    if ({busy, done, mem_enable} !== 3'b000) begin bad++; $display("FAIL b2b_single got=%b exp=000", {busy, done, mem_enable}); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_burst();
    test_clear_mid_write();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter A, default 8, meaning address width.
REQ-002 SHALL have parameter W, default 8, meaning data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clear, input, 1, the reset: asynchronous and active-low.
REQ-005 SHALL have port req, input, 1, CPU access request, sampled only when busy=0.
REQ-006 SHALL have port we, input, 1, 1=store, 0=load, sampled with req.
REQ-007 SHALL have port cpu_addr, input, A, access start address.
REQ-008 SHALL have port cpu_wdata, input, W, store data.
REQ-009 SHALL have port burst_len, input, 4, read word count minus 1; it is used only when MEMCTRL_BURST_EN is defined.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port done, output, 1, registered one-cycle completion pulse.
REQ-012 SHALL have port rvalid, output, 1, registered one-cycle pulse per returned read word.
REQ-013 SHALL have port rdata, output, W, registered read data, held until the next capture.
REQ-014 SHALL have port mem_addr, output, A, RAM address.
REQ-015 SHALL have port mem_datain, output, W, RAM write data.
REQ-016 SHALL have ports mem_enable, mem_read_en and mem_write_en, output, 1 each, RAM strobes, active-high.
REQ-017 SHALL have port mem_dataout, input, W, RAM read data, updated on the clock edge that samples mem_read_en=1.

Function
REQ-018 SHALL implement the states IDLE, RD, CAP and WR; any unreachable encoding SHALL go to IDLE on the next edge.
REQ-019 IDLE: mem_enable, mem_read_en and mem_write_en SHALL all be 0; req=1 at an edge SHALL latch addr, wdata and length and go to WR (we=1) or RD (we=0).
REQ-020 WR: drive mem_enable=1, mem_write_en=1, mem_read_en=0, mem_addr and mem_datain from the latched values for exactly one cycle; at the edge set done=1 for one cycle and go to IDLE.
REQ-021 RD: drive mem_enable=1, mem_read_en=1, mem_write_en=0; when the remaining count is 0, go to CAP at the edge, otherwise increment the address modulo 2^A, decrement the count and stay in RD.
REQ-022 CAP: drive mem_enable=1 with both read and write strobes at 0.
REQ-023 At every edge one cycle after an edge that sampled mem_read_en=1: rdata<=mem_dataout and rvalid=1 for the next cycle.
REQ-024 At the CAP edge: done=1 for the next cycle, and go to IDLE.
REQ-025 Single-word latency: store done is asserted 2 cycles after the cycle in which req is sampled; load done/rvalid is asserted 3 cycles after it.
REQ-026 req while busy=1 SHALL be ignored without queuing; req in the same cycle that done=1 in IDLE SHALL be accepted.
REQ-027 mem_write_en and mem_read_en SHALL never both be 1.
REQ-028 Burst address SHALL wrap from 2^A-1 to 0.

Reset
REQ-029 clear=0 SHALL immediately force state IDLE and set every output to 0: busy, done, rvalid, rdata, mem_addr, mem_datain and all mem strobes.
REQ-030 clear asserted mid-access SHALL abort the access with no further strobe and no done; a write aborted in WR before the edge SHALL not occur.

Configuration
REQ-031 With macro MEMCTRL_BURST_EN defined, a load SHALL read burst_len+1 consecutive words (1..16), with RD issuing one read per cycle and rvalid on each word.
REQ-032 Without MEMCTRL_BURST_EN, burst_len SHALL be ignored, every load SHALL be one word, and rvalid SHALL coincide with done.

Verification
REQ-033 Store req, we=1, addr=0x10, wdata=0xA5 -> one WR cycle with mem_write_en=1, mem_addr=0x10, mem_datain=0xA5; done 2 cycles after req is sampled.
REQ-034 Load from addr 23 with preloaded RAM (value 0x1E) -> rdata=0x1E with done=rvalid=1, 3 cycles after req is sampled.
REQ-035 Burst (macro defined), addr=0xFE, burst_len=3 -> mem_addr sequence 0xFE, 0xFF, 0x00, 0x01 on consecutive cycles; four rvalid pulses in order; done only with the fourth.
REQ-036 clear pulsed low during WR -> all outputs 0 at once, RAM content unchanged, no done.
REQ-037 req held high while busy, then kept high in the done cycle -> the held req is ignored while busy, and exactly one new access starts at the done-cycle edge.
